// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/done handshake and MIPS-style HI/LO.
// Single-cycle logic/arith/compare ops; iterative MULTU (shift-add) and
// DIVU (restoring). The divider is built only when SEQ_ALU_DIV_EN is defined;
// otherwise DIVU decodes as an undefined opcode.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [3:0]       ALUControl,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

   typedef enum logic [3:0] {
      OP_AND   = 4'b0000, OP_OR    = 4'b0001, OP_ADD   = 4'b0010,
      OP_XOR   = 4'b0011, OP_NOR   = 4'b0100, OP_SLTU  = 4'b0101,
      OP_SUB   = 4'b0110, OP_SLT   = 4'b0111, OP_MULTU = 4'b1000,
      OP_DIVU  = 4'b1001, OP_MFHI  = 4'b1010, OP_MFLO  = 4'b1011
   } op_e;

   state_e             state, state_nx;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opb;
   logic [CW-1:0]      cnt;
   logic               last;
   logic [WIDTH-1:0]   alu_res;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign last = (cnt == CW'(WIDTH - 1));

   // Shift-add step: acc holds {partial product, remaining multiplier bits}
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
      mul_next = {mul_sum, acc[WIDTH-1:1]};
   end

`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH:0]   div_sh;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;
   logic [WIDTH-1:0] rem_n;
   logic [WIDTH-1:0] quo_n;

   // Restoring step: acc holds {remainder, dividend bits shifting into quotient}.
   // A zero divisor always "subtracts", giving all-ones quotient and rem = A.
   always_comb begin
      div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_ge   = (div_sh >= {1'b0, opb});
      div_diff = div_sh[WIDTH-1:0] - opb;
      rem_n    = div_ge ? div_diff : div_sh[WIDTH-1:0];
      quo_n    = {acc[WIDTH-2:0], div_ge};
   end
`endif

   // Single-cycle result decode
   always_comb begin
      alu_res = '0;
      case (ALUControl)
         OP_AND:  alu_res = SrcA & SrcB;
         OP_OR:   alu_res = SrcA | SrcB;
         OP_ADD:  alu_res = SrcA + SrcB;
         OP_XOR:  alu_res = SrcA ^ SrcB;
         OP_NOR:  alu_res = ~(SrcA | SrcB);
         OP_SUB:  alu_res = SrcA - SrcB;
         OP_SLT:  alu_res = WIDTH'($signed(SrcA) < $signed(SrcB));
         OP_SLTU: alu_res = WIDTH'(SrcA < SrcB);
         OP_MFHI: alu_res = Hi;
         OP_MFLO: alu_res = Lo;
         default: alu_res = '0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) begin
               case (ALUControl)
                  OP_MULTU: state_nx = MUL;
`ifdef SEQ_ALU_DIV_EN
                  OP_DIVU:  state_nx = DIV;
`endif
                  default:  state_nx = DONE;
               endcase
            end
         end
         MUL:     if (last) state_nx = DONE;
`ifdef SEQ_ALU_DIV_EN
         DIV:     if (last) state_nx = DONE;
`endif
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Handshake outputs
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Datapath: operand capture, iteration, and result/HI/LO registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc       <= '0;
         opb       <= '0;
         cnt       <= '0;
         ALUResult <= '0;
         Zero      <= 1'b1;
         Hi        <= '0;
         Lo        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt <= '0;
                  case (ALUControl)
                     OP_MULTU: begin
                        acc <= {{WIDTH{1'b0}}, SrcB};
                        opb <= SrcA;
                     end
`ifdef SEQ_ALU_DIV_EN
                     OP_DIVU: begin
                        acc <= {{WIDTH{1'b0}}, SrcA};
                        opb <= SrcB;
                     end
`endif
                     default: begin
                        ALUResult <= alu_res;
                        Zero      <= (alu_res == '0);
                     end
                  endcase
               end
            end
            MUL: begin
               acc <= mul_next;
               cnt <= cnt + 1'b1;
               if (last) begin
                  Hi        <= mul_next[2*WIDTH-1:WIDTH];
                  Lo        <= mul_next[WIDTH-1:0];
                  ALUResult <= mul_next[WIDTH-1:0];
                  Zero      <= (mul_next[WIDTH-1:0] == '0);
               end
            end
`ifdef SEQ_ALU_DIV_EN
            DIV: begin
               acc <= {rem_n, quo_n};
               cnt <= cnt + 1'b1;
               if (last) begin
                  Hi        <= rem_n;
                  Lo        <= quo_n;
                  ALUResult <= quo_n;
                  Zero      <= (quo_n == '0);
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed stimulus for seq_alu (WIDTH=32) with a behavioural
// model checked against every output on every cycle after the first reset,
// plus hand-computed literal expectations.
module tb_seq_alu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] SrcA = '0;
   logic [W-1:0] SrcB = '0;
   logic [3:0]   ALUControl = '0;
   logic [W-1:0] ALUResult, Hi, Lo;
   logic         Zero, busy, done;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .SrcA(SrcA), .SrcB(SrcB),
      .ALUControl(ALUControl), .ALUResult(ALUResult), .Zero(Zero),
      .Hi(Hi), .Lo(Lo), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         multi;
   } calc_t;

   function automatic calc_t calc(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                  logic [W-1:0] hi, logic [W-1:0] lo);
      calc_t c;
      logic [2*W-1:0] p;
      c.res = '0; c.hi = hi; c.lo = lo; c.multi = 1'b0;
      case (op)
         4'd0:  c.res = a & b;
         4'd1:  c.res = a | b;
         4'd2:  c.res = a + b;
         4'd3:  c.res = a ^ b;
         4'd4:  c.res = ~(a | b);
         4'd6:  c.res = a - b;
         4'd7:  c.res = ($signed(a) < $signed(b)) ? 1 : 0;
         4'd5:  c.res = (a < b) ? 1 : 0;
         4'd8: begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            c.hi = p[2*W-1:W]; c.lo = p[W-1:0]; c.res = c.lo; c.multi = 1'b1;
         end
`ifdef SEQ_ALU_DIV_EN
         4'd9: begin
            if (b == 0) begin c.lo = '1; c.hi = a; end
            else begin c.lo = a / b; c.hi = a % b; end
            c.res = c.lo; c.multi = 1'b1;
         end
`endif
         4'd10: c.res = hi;
         4'd11: c.res = lo;
         default: c.res = '0;
      endcase
      return c;
   endfunction

   logic         m_valid = 1'b0;
   logic [W-1:0] m_res, m_hi, m_lo;
   logic         m_zero, m_busy, m_done;
   int           m_cnt;
   calc_t        m_pend, m_c;

   always_comb m_c = calc(ALUControl, SrcA, SrcB, m_hi, m_lo);

   always @(posedge clk) begin
      if (!reset_n) begin
         m_valid <= 1'b1;
         m_res <= '0; m_zero <= 1'b1; m_hi <= '0; m_lo <= '0;
         m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy <= 1'b1;
            if (m_c.multi) begin
               m_pend <= m_c; m_cnt <= W; m_done <= 1'b0;
            end else begin
               m_res <= m_c.res; m_zero <= (m_c.res == 0); m_done <= 1'b1;
            end
         end
      end else if (m_done) begin
         m_busy <= 1'b0; m_done <= 1'b0;
      end else if (m_cnt == 1) begin
         m_res <= m_pend.res; m_zero <= (m_pend.res == 0);
         m_hi <= m_pend.hi; m_lo <= m_pend.lo;
         m_done <= 1'b1; m_cnt <= 0;
      end else begin
         m_cnt <= m_cnt - 1;
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask

   // Advance one cycle and compare every output against the model
   task automatic step();
      @(negedge clk);
      if (m_valid) begin
         chk("ALUResult", ALUResult, m_res);
         chk("Zero", Zero, m_zero);
         chk("Hi", Hi, m_hi);
         chk("Lo", Lo, m_lo);
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
      end
   endtask

   // Issue one op, scramble inputs after acceptance, wait for done, return to IDLE
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
      ALUControl = op; SrcA = a; SrcB = b; start = 1'b1;
      step();
      start = 1'b0;
      SrcA = $urandom; SrcB = $urandom; ALUControl = 4'($urandom);
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         step();
         lat++;
      end
      if (done !== 1'b1) chk("done_timeout", done, 1);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int lat;
      int pulses;

      // reset for 2 cycles with start asserted (must be ignored)
      reset_n = 1'b0; start = 1'b1; ALUControl = 4'd2; SrcA = 32'd1; SrcB = 32'd1;
      step(); step();
      reset_n = 1'b1; start = 1'b0;
      step();
      chk("rst_res", ALUResult, 0);
      chk("rst_zero", Zero, 1);
      chk("rst_hi", Hi, 0);
      chk("rst_lo", Lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);

      // single-cycle ops
      issue(4'd6, 32'd5, 32'd5, lat);
      chk("sub_lat", lat, 1);
      chk("sub_res", ALUResult, 0);
      chk("sub_zero", Zero, 1);
      issue(4'd7, 32'hFFFF_FFFF, 32'd1, lat);
      chk("slt_res", ALUResult, 1);
      chk("slt_zero", Zero, 0);
      issue(4'd5, 32'hFFFF_FFFF, 32'd1, lat);
      chk("sltu_res", ALUResult, 0);
      issue(4'd4, 32'd0, 32'd0, lat);
      chk("nor_res", ALUResult, 32'hFFFF_FFFF);
      issue(4'd2, 32'hFFFF_FFFF, 32'd2, lat);
      chk("add_wrap", ALUResult, 1);
      issue(4'd0, 32'hF0F0_1234, 32'h0FF0_FF00, lat);
      chk("and_res", ALUResult, 32'h00F0_1200);
      issue(4'd1, 32'hA000_0001, 32'h0500_0010, lat);
      issue(4'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, lat);
      chk("xor_res", ALUResult, 32'hF0F0_0F0F);
      issue(4'd6, 32'd0, 32'd1, lat);
      chk("sub_wrap", ALUResult, 32'hFFFF_FFFF);

      // multiply
      issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      chk("mul_lat", lat, 33);
      chk("mul_hi", Hi, 32'hFFFF_FFFE);
      chk("mul_lo", Lo, 32'h0000_0001);
      chk("mul_res", ALUResult, 32'h0000_0001);
      issue(4'd10, 32'd0, 32'd0, lat);
      chk("mfhi_res", ALUResult, 32'hFFFF_FFFE);
      issue(4'd11, 32'd0, 32'd0, lat);
      chk("mflo_res", ALUResult, 1);
      issue(4'd8, 32'd0, 32'h1234_5678, lat);
      chk("mul0_zero", Zero, 1);
      issue(4'd8, 32'h0001_0000, 32'h0003_0000, lat);
      chk("mul_hi2", Hi, 32'd3);
      chk("mul_lo2", Lo, 32'd0);

      // undefined opcode leaves HI/LO alone
      issue(4'd12, 32'd7, 32'd9, lat);
      chk("undef_res", ALUResult, 0);
      chk("undef_hi", Hi, 32'd3);

      // divide
      issue(4'd9, 32'd100, 32'd7, lat);
`ifdef SEQ_ALU_DIV_EN
      chk("div_lat", lat, 33);
      chk("div_lo", Lo, 14);
      chk("div_hi", Hi, 2);
      chk("div_res", ALUResult, 14);
      issue(4'd9, 32'd9, 32'd0, lat);
      chk("div0_lo", Lo, 32'hFFFF_FFFF);
      chk("div0_hi", Hi, 9);
      chk("div0_lat", lat, 33);
      issue(4'd9, 32'hFFFF_FFFF, 32'h0001_0000, lat);
      chk("div_big_lo", Lo, 32'h0000_FFFF);
      chk("div_big_hi", Hi, 32'h0000_FFFF);
`else
      chk("div_lat", lat, 1);
      chk("div_res", ALUResult, 0);
      chk("div_zero", Zero, 1);
      chk("div_hi_keep", Hi, 32'd3);
      chk("div_lo_keep", Lo, 32'd0);
`endif

      // start pulse during MULTU is ignored
      ALUControl = 4'd8; SrcA = 32'd6; SrcB = 32'd7; start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      ALUControl = 4'd2; SrcA = 32'd1; SrcB = 32'd2; start = 1'b1;
      step();
      start = 1'b0;
      lat = 5;
      while (done !== 1'b1 && lat < 100) begin
         chk("busy_hold", busy, 1);
         step();
         lat++;
      end
      chk("busy_mul_lat", lat, 33);
      chk("busy_mul_res", ALUResult, 42);
      step();
      chk("busy_idle", busy, 0);

      // start held high re-issues every 2 cycles
      ALUControl = 4'd2; SrcA = 32'd3; SrcB = 32'd4; start = 1'b1;
      pulses = 0;
      repeat (4) begin
         step();
         if (done === 1'b1) pulses++;
      end
      start = 1'b0;
      step();
      chk("reissue_pulses", pulses, 2);
      chk("reissue_res", ALUResult, 7);

      // reset in the middle of MULTU and DIVU
      for (int k = 0; k < 2; k++) begin
         ALUControl = (k == 0) ? 4'd8 : 4'd9;
         SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
         step();
         start = 1'b0;
         repeat (8) step();
         reset_n = 1'b0;
         step();
         reset_n = 1'b1;
         chk("abort_res", ALUResult, 0);
         chk("abort_zero", Zero, 1);
         chk("abort_hi", Hi, 0);
         chk("abort_lo", Lo, 0);
         chk("abort_busy", busy, 0);
         pulses = 0;
         repeat (40) begin
            step();
            if (done === 1'b1) pulses++;
         end
         chk("abort_no_done", pulses, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
